// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage pipelined bitwise gate unit (AND/OR/NAND/NOR/XOR/XNOR/NOT A) with zero/parity/error flags.
// Latency: accept at edge N, result valid after edge N+1, consumed at N+2 at the earliest; one word per cycle sustained.
// Backpressure: in_ready is combinational from out_ready (no skid buffer); capacity 2 words; LOGIC_GATE_PIPE_STATS_EN enables stat_count.
module logic_gate_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_parity,
  output logic             out_err,
  output logic [15:0]      stat_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;

  logic             s2_load;
  logic             s1_load;
  logic [WIDTH-1:0] res;

  // S2 frees when empty or being drained; S1 frees when empty or moving into S2.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Gate function on the S1 word; reserved opcode forces a zero result.
  always_comb begin
    res = '0;
    case (s1_op)
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_NAND: res = ~(s1_a & s1_b);
      OP_NOR:  res = ~(s1_a | s1_b);
      OP_XOR:  res = s1_a ^ s1_b;
      OP_XNOR: res = ~(s1_a ^ s1_b);
      OP_NOTA: res = ~s1_a;
      default: res = '0;
    endcase
  end

  // Stage 1: capture operands whenever the stage can take a new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
    end
  end

  // Stage 2: result and flags are loaded together so they stay coherent; they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y      <= res;
        out_zero   <= (res == '0);
        out_parity <= ^res;
        out_err    <= (s1_op == OP_RSVD);
      end
    end
  end

`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [15:0] stat_q;

  // Saturating count of output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (out_valid && out_ready && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_count = stat_q;
`else
  assign stat_count = 16'h0000;
`endif

endmodule
